tone_seq_gen: RTL
=================

# tone_seq_gen

Parametrised square-wave tone generator for the alarm sound path. Accepts one note per handshake (frequency in Hz plus duration in beat ticks), computes the half-period internally with an iterative divider, then plays a 50 %-duty tone for the requested duration and pulses `done`. It sits between the melody/alarm sequencer and the speaker PWM pin, and adds rests, pause, abort and clamping to the existing fixed-rate tone path.

## Interface
- `CLK_HZ`, 5_000_000: input clock frequency in Hz; the dividend of the period calculation.
- `FW`, 23: width of the `freq` input.
- `DW`, 16: width of the `dur` input.
- `TICK_DIV`, 5000: clock cycles per duration tick (1 ms at default `CLK_HZ`).
- Local `CW = $clog2(CLK_HZ+1)`: quotient and phase-counter width.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: 1 = run; 0 = pause (see Operation).
- `abort` in 1: synchronous cancel of the current note.
- `note_valid` in 1: note request.
- `note_ready` out 1: block can accept a note.
- `freq` in FW: tone frequency in Hz; 0 = rest.
- `dur` in DW: note length in ticks.
- `tone` out 1: square-wave output, registered.
- `busy` out 1: high in DIV or PLAY.
- `done` out 1: one-cycle pulse at note completion.

## Operation
- Reset values: state IDLE, `tone`=0, `busy`=0, `done`=0, `note_ready`=1, all counters 0.
- States:
  - IDLE
    - `note_ready`=1.
    - On `note_valid`: latch `freq` and `dur` and go to DIV.
  - DIV
    - Restoring divider computes `q = CLK_HZ / freq_latched`, one quotient bit per cycle, exactly CW cycles.
    - Then go to PLAY, or to IDLE with a `done` pulse if `dur_latched`=0.
  - PLAY
    - Phase counter `ph` runs 0..q-1 and wraps.
    - `tone` is registered as `(ph >= q>>1)`.
    - Tick counter runs 0..TICK_DIV-1; each wrap decrements the remaining duration.
    - When the last tick ends: go to IDLE, `done`=1 for one cycle, `tone`=0.
- Rest: if `freq_latched`=0, skip division (`q` undefined). The duration still runs and `tone` stays 0. DIV still takes CW cycles so latency is uniform.
- Clamp: if `q` < 2 (freq > CLK_HZ/2), use `q`=2.
- Odd `q`: low for floor(q/2) cycles, high for ceil(q/2).
- `enable`=0:
  - All counters and state freeze; `tone` is forced to 0.
  - On resume, continue from the frozen values.
  - The handshake is also blocked: `note_ready`=0 while `enable`=0.
- `abort`:
  - In any state, return to IDLE next cycle with `tone`=0 and `busy`=0.
  - No `done` pulse is issued.
  - `abort` takes priority over `note_valid` and `enable`.
- `rst` mid-note: immediate return to reset values, without waiting for a clock edge.
- `note_valid` while not ready is ignored; the sender holds it.

## Timing
- Note accepted at edge N.
  - DIV occupies edges N+1..N+CW.
  - PLAY first cycle is edge N+CW+1; `tone` first reflects `ph`=0 at edge N+CW+2.
- PLAY length = `dur`·TICK_DIV enabled cycles.
- `done` coincides with the first IDLE cycle, and `note_ready`=1 in that same cycle. A back-to-back note can be accepted on the `done` cycle, giving a gap of CW+1 cycles between notes.
- `busy` = (state != IDLE), registered together with state.

## Test plan
- Parameters for all scenarios: `CLK_HZ`=1000, `TICK_DIV`=10, CW=10.
- Basic note: `freq`=100, `dur`=3 → after 10 DIV cycles, `tone` shows period 10 (5 low / 5 high) for 30 cycles, then a single `done` pulse and `note_ready`=1.
- Odd period and clamp:
  - `freq`=143 → `q`=6 (3/3).
  - `freq`=333 → `q`=3 (1 low / 2 high).
  - `freq`=900 → `q` clamped to 2 (1/1).
- Rest and zero duration:
  - `freq`=0, `dur`=2 → `tone`=0 for 20 cycles, then `done`.
  - `freq`=100, `dur`=0 → `done` right after DIV with no tone.
- Pause: drop `enable` for 7 cycles mid-PLAY → `tone`=0 during the pause; the waveform resumes in the same phase and `done` is delayed by exactly 7 cycles.
- Abort and reset:
  - `abort` mid-PLAY → IDLE next cycle, no `done`, `tone`=0.
  - Async `rst` asserted between edges → outputs go to reset values immediately.
- Back-to-back: `note_valid` held high with two notes → second accepted on the `done` cycle, second note's DIV starts the next cycle.

Source files
------------

// File: rtl/tone_seq_if.sv
// Note request handshake between the melody/alarm sequencer and tone_seq_gen.
interface tone_seq_if #(
  parameter int FW = 23,
  parameter int DW = 16
);
  logic          note_valid;
  logic          note_ready;
  logic [FW-1:0] freq;
  logic [DW-1:0] dur;

  modport master (output note_valid, output freq, output dur, input note_ready);
  modport slave  (input note_valid, input freq, input dur, output note_ready);
endinterface

// File: rtl/tone_seq_gen.sv
// Square-wave tone generator: one note per handshake, half-period derived by an
// iterative restoring divider, then a 50% duty tone for dur beat ticks.
module tone_seq_gen #(
  parameter int CLK_HZ   = 5_000_000,
  parameter int FW       = 23,
  parameter int DW       = 16,
  parameter int TICK_DIV = 5000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enable,
  input  logic      abort,
  tone_seq_if.slave note,
  output logic      tone,
  output logic      busy,
  output logic      done
);
  localparam int CW  = $clog2(CLK_HZ + 1);
  localparam int DCW = $clog2(CW + 1);
  localparam int TW  = $clog2(TICK_DIV + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;

  logic [1:0]     state;
  logic [FW-1:0]  freq_l;
  logic [DW-1:0]  remain;
  logic [CW-1:0]  dvd;
  logic [FW-1:0]  rem;
  logic [CW-1:0]  q;
  logic [DCW-1:0] div_cnt;
  logic [CW-1:0]  ph;
  logic [TW-1:0]  tick;
  logic           tone_q;

  logic [FW:0]    rem_sh;
  logic           q_bit;
  logic [CW-1:0]  q_next;
  logic           accept;

  always_comb begin
    rem_sh = {rem, dvd[CW-1]};
    q_bit  = (rem_sh >= {1'b0, freq_l});
    q_next = {q[CW-2:0], q_bit};
  end

  assign note.note_ready = (state == IDLE) && enable;
  assign accept          = note.note_valid && note.note_ready && !abort;
  // Masking keeps the registered phase intact across a pause so resume is seamless.
  assign tone            = tone_q && enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      tone_q  <= 1'b0;
      freq_l  <= '0;
      remain  <= '0;
      dvd     <= '0;
      rem     <= '0;
      q       <= '0;
      div_cnt <= '0;
      ph      <= '0;
      tick    <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        busy   <= 1'b0;
        tone_q <= 1'b0;
      end else if (enable) begin
        case (state)
          IDLE: begin
            if (accept) begin
              freq_l  <= note.freq;
              remain  <= note.dur;
              dvd     <= CW'(CLK_HZ);
              rem     <= '0;
              q       <= '0;
              div_cnt <= '0;
              state   <= DIV;
              busy    <= 1'b1;
            end
          end
          DIV: begin
            // A rest still walks all CW steps so every note has the same latency.
            dvd     <= {dvd[CW-2:0], 1'b0};
            rem     <= q_bit ? (rem_sh[FW-1:0] - freq_l) : rem_sh[FW-1:0];
            q       <= q_next;
            div_cnt <= div_cnt + DCW'(1);
            if (div_cnt == DCW'(CW - 1)) begin
              if (q_next < CW'(2)) q <= CW'(2);
              ph   <= '0;
              tick <= '0;
              if (remain == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= PLAY;
              end
            end
          end
          PLAY: begin
            tone_q <= (freq_l != '0) && (ph >= (q >> 1));
            ph     <= (ph == q - CW'(1)) ? '0 : ph + CW'(1);
            if (tick == TW'(TICK_DIV - 1)) begin
              tick   <= '0;
              remain <= remain - DW'(1);
              if (remain == DW'(1)) begin
                state  <= IDLE;
                busy   <= 1'b0;
                done   <= 1'b1;
                tone_q <= 1'b0;
              end
            end else begin
              tick <= tick + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
